// File: rtl/ctrl_pkg.sv
package ctrl_pkg;

  typedef enum logic [3:0] {
    INIT,
    FETCH,
    FETCH_LATCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    EXEC_LUI,
    WB_ALU,
    ADDR,
    MEM_RD,
    WB_MEM,
    MEM_WR,
    BRANCH,
    JAL,
    HALT
  } state_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [2:0] ALU_NOP   = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b101;
  localparam logic [2:0] ALU_SLT   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_fct;
    logic       imem_read;
    logic       load_ir;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       dmem_read;
    logic       dmem_write;
    logic       halt;
  } ctrl_out_t;

  function automatic ctrl_out_t moore_outputs(input state_e s, input logic [2:0] exec_fct);
    ctrl_out_t o;
    o = '0;
    case (s)
      FETCH: begin
        o.imem_read = 1'b1;
        o.alu_src_a = SRCA_PC;
        o.alu_src_b = SRCB_FOUR;
        o.alu_fct   = ALU_ADD;
      end
      FETCH_LATCH: begin
        o.alu_src_a = SRCA_PC;
        o.alu_src_b = SRCB_FOUR;
        o.alu_fct   = ALU_ADD;
        o.pc_write  = 1'b1;
        o.pc_src    = 1'b0;
        o.load_ir   = 1'b1;
      end
      DECODE: begin
        o.alu_src_a = SRCA_OLDPC;
        o.alu_src_b = SRCB_IMM;
        o.alu_fct   = ALU_ADD;
      end
      EXEC_R: begin
        o.alu_src_a = SRCA_RS1;
        o.alu_src_b = SRCB_RS2;
        o.alu_fct   = exec_fct;
      end
      EXEC_I: begin
        o.alu_src_a = SRCA_RS1;
        o.alu_src_b = SRCB_IMM;
        o.alu_fct   = exec_fct;
      end
      EXEC_LUI: begin
        o.alu_src_b = SRCB_IMM;
        o.alu_fct   = ALU_PASSB;
      end
      WB_ALU: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = M2R_ALUOUT;
      end
      ADDR: begin
        o.alu_src_a = SRCA_RS1;
        o.alu_src_b = SRCB_IMM;
        o.alu_fct   = ALU_ADD;
      end
      MEM_RD: o.dmem_read = 1'b1;
      WB_MEM: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = M2R_MDR;
      end
      MEM_WR: o.dmem_write = 1'b1;
      BRANCH: begin
        o.alu_src_a = SRCA_RS1;
        o.alu_src_b = SRCB_RS2;
        o.alu_fct   = ALU_SUB;
        o.pc_src    = 1'b1;
      end
      JAL: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = M2R_PC;
        o.pc_write   = 1'b1;
        o.pc_src     = 1'b1;
      end
      HALT: o.halt = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/alu_fct_decoder.sv
module alu_fct_decoder
  import ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output logic [2:0] alu_fct,
  output logic       illegal
);

  always_comb begin
    alu_fct = ALU_NOP;
    illegal = 1'b0;
    case (funct3)
      3'b000:  alu_fct = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_fct = ALU_AND;
      3'b110:  alu_fct = ALU_OR;
      3'b100:  alu_fct = ALU_XOR;
      3'b010:  alu_fct = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       Zero,
  input  logic       DmemReady,
  output logic       PCwrite,
  output logic       PCSrc,
  output logic [1:0] AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [2:0] ALUFct,
  output logic       ImemRead,
  output logic       LoadIr,
  output logic       RegWrite,
  output logic [1:0] MemToReg,
  output logic       DmemRead,
  output logic       DmemWrite,
  output logic       Halt,
  output logic [1:0] Fault
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]       fault_q, fault_d;
  ctrl_out_t        out_q, out_d;

  logic       is_rtype;
  logic [2:0] exec_fct;
  logic       fct_illegal;
  logic       branch_legal;
  logic       branch_take;

  assign is_rtype = (Opcode == OP_RTYPE);

  alu_fct_decoder u_alu_fct_decoder (
    .funct3   (Funct3),
    .funct7b5 (Funct7b5),
    .is_rtype (is_rtype),
    .alu_fct  (exec_fct),
    .illegal  (fct_illegal)
  );

  assign branch_legal = (Funct3 == F3_BEQ) || (Funct3 == F3_BNE);
  assign branch_take  = ((Funct3 == F3_BEQ) && Zero) || ((Funct3 == F3_BNE) && !Zero);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    fault_d    = fault_q;
    case (state_q)
      INIT:        state_d = FETCH;
      FETCH:       state_d = FETCH_LATCH;
      FETCH_LATCH: state_d = DECODE;
      DECODE: begin
        case (Opcode)
          OP_RTYPE:          state_d = EXEC_R;
          OP_ITYPE:          state_d = EXEC_I;
          OP_LOAD, OP_STORE: state_d = ADDR;
          OP_BRANCH:         state_d = BRANCH;
          OP_LUI:            state_d = EXEC_LUI;
          OP_JAL:            state_d = JAL;
          default: begin
            state_d = HALT;
            fault_d = FAULT_ILLEGAL;
          end
        endcase
      end
      EXEC_R, EXEC_I: begin
        if (fct_illegal) begin
          state_d = HALT;
          fault_d = FAULT_ILLEGAL;
        end else begin
          state_d = WB_ALU;
        end
      end
      EXEC_LUI:       state_d = WB_ALU;
      WB_ALU, WB_MEM: state_d = FETCH;
      ADDR: begin
        wait_cnt_d = '0;
        if (Funct3 != F3_WORD) begin
          state_d = HALT;
          fault_d = FAULT_ILLEGAL;
        end else if (Opcode == OP_LOAD) begin
          state_d = MEM_RD;
        end else begin
          state_d = MEM_WR;
        end
      end
      MEM_RD, MEM_WR: begin
        // Ready on the limit cycle still completes the access.
        if (DmemReady) begin
          if (state_q == MEM_RD) state_d = WB_MEM;
          else                   state_d = FETCH;
        end else if (wait_cnt_q == CNT_LIMIT) begin
          state_d = HALT;
          fault_d = FAULT_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      BRANCH: begin
        if (branch_legal) begin
          state_d = FETCH;
        end else begin
          state_d = HALT;
          fault_d = FAULT_ILLEGAL;
        end
      end
      JAL:     state_d = FETCH;
      default: state_d = state_q;
    endcase
    // Outputs are pre-decoded from the next state so the registered copy
    // matches the Moore value of the state it accompanies.
    out_d = moore_outputs(state_d, exec_fct);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= INIT;
      wait_cnt_q <= '0;
      fault_q    <= FAULT_NONE;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
      out_q      <= out_d;
    end
  end

  assign PCwrite   = out_q.pc_write | ((state_q == BRANCH) & branch_take);
  assign PCSrc     = out_q.pc_src;
  assign AluSrcA   = out_q.alu_src_a;
  assign AluSrcB   = out_q.alu_src_b;
  assign ALUFct    = out_q.alu_fct;
  assign ImemRead  = out_q.imem_read;
  assign LoadIr    = out_q.load_ir;
  assign RegWrite  = out_q.reg_write;
  assign MemToReg  = out_q.mem_to_reg;
  assign DmemRead  = out_q.dmem_read;
  assign DmemWrite = out_q.dmem_write;
  assign Halt      = out_q.halt;
  assign Fault     = fault_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;
  import ctrl_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [6:0] Opcode = '0;
  logic [2:0] Funct3 = '0;
  logic       Funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       DmemReady = 1'b0;
  logic       PCwrite, PCSrc, ImemRead, LoadIr, RegWrite, DmemRead, DmemWrite, Halt;
  logic [1:0] AluSrcA, AluSrcB, MemToReg, Fault;
  logic [2:0] ALUFct;

  always #5 Clk = ~Clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Opcode    (Opcode),
    .Funct3    (Funct3),
    .Funct7b5  (Funct7b5),
    .Zero      (Zero),
    .DmemReady (DmemReady),
    .PCwrite   (PCwrite),
    .PCSrc     (PCSrc),
    .AluSrcA   (AluSrcA),
    .AluSrcB   (AluSrcB),
    .ALUFct    (ALUFct),
    .ImemRead  (ImemRead),
    .LoadIr    (LoadIr),
    .RegWrite  (RegWrite),
    .MemToReg  (MemToReg),
    .DmemRead  (DmemRead),
    .DmemWrite (DmemWrite),
    .Halt      (Halt),
    .Fault     (Fault)
  );

  typedef struct packed {
    logic       pcw;
    logic       pcsrc;
    logic [1:0] asa;
    logic [1:0] asb;
    logic [2:0] fct;
    logic       imem;
    logic       ldir;
    logic       rw;
    logic [1:0] m2r;
    logic       dr;
    logic       dw;
    logic       halt;
    logic [1:0] fault;
  } exp_t;

  typedef struct {
    string      tag;
    logic       rst;
    logic       rdy;
    logic       zero;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    exp_t       exp;
  } entry_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [1:0] asa;
    logic [1:0] asb;
    logic [2:0] fct;
  } alu_case_t;

  entry_t     sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [6:0] cur_op = '0;
  logic [2:0] cur_f3 = '0;
  logic       cur_f7 = 1'b0;

  function automatic exp_t e_idle();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic exp_t e_fetch();
    exp_t e;
    e = '0; e.imem = 1'b1; e.asb = 2'b01; e.fct = 3'b001;
    return e;
  endfunction

  function automatic exp_t e_latch();
    exp_t e;
    e = '0; e.asb = 2'b01; e.fct = 3'b001; e.pcw = 1'b1; e.ldir = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_decode();
    exp_t e;
    e = '0; e.asa = 2'b01; e.asb = 2'b10; e.fct = 3'b001;
    return e;
  endfunction

  function automatic exp_t e_alu(input logic [1:0] asa, input logic [1:0] asb, input logic [2:0] fct);
    exp_t e;
    e = '0; e.asa = asa; e.asb = asb; e.fct = fct;
    return e;
  endfunction

  function automatic exp_t e_wb(input logic [1:0] m2r);
    exp_t e;
    e = '0; e.rw = 1'b1; e.m2r = m2r;
    return e;
  endfunction

  function automatic exp_t e_mem(input logic wr);
    exp_t e;
    e = '0;
    if (wr) e.dw = 1'b1;
    else    e.dr = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_branch(input logic pcw);
    exp_t e;
    e = '0; e.asa = 2'b10; e.asb = 2'b00; e.fct = 3'b010; e.pcsrc = 1'b1; e.pcw = pcw;
    return e;
  endfunction

  function automatic exp_t e_jal();
    exp_t e;
    e = '0; e.rw = 1'b1; e.m2r = 2'b10; e.pcw = 1'b1; e.pcsrc = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_halt(input logic [1:0] fault);
    exp_t e;
    e = '0; e.halt = 1'b1; e.fault = fault;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t s;
    s.pcw = PCwrite;    s.pcsrc = PCSrc;   s.asa = AluSrcA;   s.asb = AluSrcB;
    s.fct = ALUFct;     s.imem = ImemRead; s.ldir = LoadIr;   s.rw = RegWrite;
    s.m2r = MemToReg;   s.dr = DmemRead;   s.dw = DmemWrite;  s.halt = Halt;
    s.fault = Fault;
    return s;
  endfunction

  function automatic void set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    cur_op = op; cur_f3 = f3; cur_f7 = f7;
  endfunction

  function automatic void push(input string tag, input exp_t e, input logic rdy, input logic zero, input logic rst);
    entry_t t;
    t.tag = tag; t.exp = e; t.rdy = rdy; t.zero = zero; t.rst = rst;
    t.op = cur_op; t.f3 = cur_f3; t.f7 = cur_f7;
    sb.push_back(t);
  endfunction

  function automatic void push_prefix(input string tag, input logic rdy);
    push({tag, "_fetch"},  e_fetch(),  rdy, 1'b0, 1'b0);
    push({tag, "_latch"},  e_latch(),  rdy, 1'b0, 1'b0);
    push({tag, "_decode"}, e_decode(), rdy, 1'b0, 1'b0);
  endfunction

  // One clock cycle: inputs change just after the rising edge, outputs are
  // sampled on the falling edge.
  task automatic step(input entry_t t);
    @(posedge Clk);
    #1;
    Reset = t.rst; DmemReady = t.rdy; Zero = t.zero;
    Opcode = t.op; Funct3 = t.f3; Funct7b5 = t.f7;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    entry_t t;
    exp_t   got;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    got = sample();
    checks++;
    if (got !== e_idle()) begin
      errors++; $display("FAIL reset_outputs got=%h required=%h", got, e_idle());
    end
    checks++;
    if (dut.state_q !== INIT) begin
      errors++; $display("FAIL reset_state got=%0d required=%0d", dut.state_q, INIT);
    end
    set_instr('0, '0, 1'b0);
    push("rst_hold",    e_idle(), 1'b0, 1'b0, 1'b1);
    push("rst_release", e_idle(), 1'b0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      t = sb.pop_front(); step(t); got = sample(); checks++;
      if (got !== t.exp) begin errors++; $display("FAIL %s got=%h required=%h", t.tag, got, t.exp); end
    end
  endtask

  task automatic test_r_sub();
    entry_t t;
    exp_t   got;
    set_instr(7'b0110011, 3'b000, 1'b1);
    push_prefix("sub", 1'b0);
    push("sub_exec", e_alu(2'b10, 2'b00, 3'b010), 1'b0, 1'b0, 1'b0);
    push("sub_wb",   e_wb(2'b00),                 1'b0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      t = sb.pop_front(); step(t); got = sample(); checks++;
      if (got !== t.exp) begin errors++; $display("FAIL %s got=%h required=%h", t.tag, got, t.exp); end
    end
  endtask

  task automatic test_alu_ops();
    alu_case_t cases [6] = '{
      '{7'b0110011, 3'b100, 1'b0, 2'b10, 2'b00, 3'b101},
      '{7'b0010011, 3'b000, 1'b1, 2'b10, 2'b10, 3'b001},
      '{7'b0010011, 3'b010, 1'b0, 2'b10, 2'b10, 3'b110},
      '{7'b0110011, 3'b110, 1'b0, 2'b10, 2'b00, 3'b100},
      '{7'b0110011, 3'b111, 1'b1, 2'b10, 2'b00, 3'b011},
      '{7'b0110111, 3'b000, 1'b0, 2'b00, 2'b10, 3'b111}
    };
    entry_t t;
    exp_t   got;
    for (int i = 0; i < 6; i++) begin
      set_instr(cases[i].op, cases[i].f3, cases[i].f7);
      push_prefix($sformatf("alu%0d", i), 1'b0);
      push($sformatf("alu%0d_exec", i), e_alu(cases[i].asa, cases[i].asb, cases[i].fct), 1'b0, 1'b0, 1'b0);
      push($sformatf("alu%0d_wb", i), e_wb(2'b00), 1'b0, 1'b0, 1'b0);
      while (sb.size() > 0) begin
        t = sb.pop_front(); step(t); got = sample(); checks++;
        if (got !== t.exp) begin errors++; $display("FAIL %s got=%h required=%h", t.tag, got, t.exp); end
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [4] = '{3'b000, 3'b001, 3'b001, 3'b000};
    logic       zs  [4] = '{1'b1,   1'b1,   1'b0,   1'b0};
    logic       tk  [4] = '{1'b1,   1'b0,   1'b1,   1'b0};
    entry_t t;
    exp_t   got;
    for (int i = 0; i < 4; i++) begin
      set_instr(7'b1100011, f3s[i], 1'b0);
      push_prefix($sformatf("br%0d", i), 1'b0);
      push($sformatf("br%0d_branch", i), e_branch(tk[i]), 1'b0, zs[i], 1'b0);
      while (sb.size() > 0) begin
        t = sb.pop_front(); step(t); got = sample(); checks++;
        if (got !== t.exp) begin errors++; $display("FAIL %s got=%h required=%h", t.tag, got, t.exp); end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    entry_t t;
    exp_t   got;
    set_instr(7'b0000011, 3'b010, 1'b0);
    push_prefix("midrst", 1'b0);
    push("midrst_addr", e_alu(2'b10, 2'b10, 3'b001), 1'b0, 1'b0, 1'b0);
    push("midrst_rd0",  e_mem(1'b0),                 1'b0, 1'b0, 1'b0);
    push("midrst_rd1",  e_mem(1'b0),                 1'b0, 1'b0, 1'b1);
    push("midrst_init", e_idle(),                    1'b0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      t = sb.pop_front(); step(t); got = sample(); checks++;
      if (got !== t.exp) begin errors++; $display("FAIL %s got=%h required=%h", t.tag, got, t.exp); end
    end
    checks++;
    if (dut.state_q !== INIT) begin
      errors++; $display("FAIL midrst_state got=%0d required=%0d", dut.state_q, INIT);
    end
  endtask

  task automatic test_load();
    entry_t t;
    exp_t   got;
    set_instr(7'b0000011, 3'b010, 1'b0);
    push_prefix("lw3", 1'b0);
    push("lw3_addr", e_alu(2'b10, 2'b10, 3'b001), 1'b0, 1'b0, 1'b0);
    push("lw3_rd0",  e_mem(1'b0), 1'b0, 1'b0, 1'b0);
    push("lw3_rd1",  e_mem(1'b0), 1'b0, 1'b0, 1'b0);
    push("lw3_rd2",  e_mem(1'b0), 1'b1, 1'b0, 1'b0);
    push("lw3_wb",   e_wb(2'b01), 1'b0, 1'b0, 1'b0);
    push_prefix("lwlim", 1'b0);
    push("lwlim_addr", e_alu(2'b10, 2'b10, 3'b001), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      push($sformatf("lwlim_rd%0d", i), e_mem(1'b0), (i == 4), 1'b0, 1'b0);
    push("lwlim_wb", e_wb(2'b01), 1'b0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      t = sb.pop_front(); step(t); got = sample(); checks++;
      if (got !== t.exp) begin errors++; $display("FAIL %s got=%h required=%h", t.tag, got, t.exp); end
    end
  endtask

  task automatic test_store();
    entry_t t;
    exp_t   got;
    set_instr(7'b0100011, 3'b010, 1'b0);
    push_prefix("sw", 1'b1);
    push("sw_addr", e_alu(2'b10, 2'b10, 3'b001), 1'b1, 1'b0, 1'b0);
    push("sw_wr",   e_mem(1'b1),                 1'b1, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      t = sb.pop_front(); step(t); got = sample(); checks++;
      if (got !== t.exp) begin errors++; $display("FAIL %s got=%h required=%h", t.tag, got, t.exp); end
    end
  endtask

  task automatic test_jal();
    entry_t t;
    exp_t   got;
    set_instr(7'b1101111, 3'b000, 1'b0);
    push_prefix("jal", 1'b0);
    push("jal_exec", e_jal(), 1'b0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      t = sb.pop_front(); step(t); got = sample(); checks++;
      if (got !== t.exp) begin errors++; $display("FAIL %s got=%h required=%h", t.tag, got, t.exp); end
    end
  endtask

  task automatic test_store_timeout();
    entry_t t;
    exp_t   got;
    set_instr(7'b0100011, 3'b010, 1'b0);
    push_prefix("swto", 1'b0);
    push("swto_addr", e_alu(2'b10, 2'b10, 3'b001), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      push($sformatf("swto_wr%0d", i), e_mem(1'b1), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      push($sformatf("swto_halt%0d", i), e_halt(2'b10), 1'b1, 1'b0, 1'b0);
    push("swto_halt_rst", e_halt(2'b10), 1'b0, 1'b0, 1'b1);
    push("swto_init",     e_idle(),      1'b0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      t = sb.pop_front(); step(t); got = sample(); checks++;
      if (got !== t.exp) begin errors++; $display("FAIL %s got=%h required=%h", t.tag, got, t.exp); end
    end
  endtask

  task automatic test_illegal();
    entry_t t;
    exp_t   got;
    set_instr(7'b1110011, 3'b000, 1'b0);
    push_prefix("ill_op", 1'b0);
    push("ill_op_halt0",   e_halt(2'b01), 1'b0, 1'b0, 1'b0);
    push("ill_op_halt1",   e_halt(2'b01), 1'b0, 1'b0, 1'b1);
    push("ill_op_init",    e_idle(),      1'b0, 1'b0, 1'b0);
    set_instr(7'b0000011, 3'b000, 1'b0);
    push_prefix("ill_lb", 1'b0);
    push("ill_lb_addr",    e_alu(2'b10, 2'b10, 3'b001), 1'b0, 1'b0, 1'b0);
    push("ill_lb_halt0",   e_halt(2'b01), 1'b0, 1'b0, 1'b0);
    push("ill_lb_halt1",   e_halt(2'b01), 1'b0, 1'b0, 1'b1);
    push("ill_lb_init",    e_idle(),      1'b0, 1'b0, 1'b0);
    push("final_fetch",    e_fetch(),     1'b0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      t = sb.pop_front(); step(t); got = sample(); checks++;
      if (got !== t.exp) begin errors++; $display("FAIL %s got=%h required=%h", t.tag, got, t.exp); end
    end
  endtask

  initial begin
    test_reset();
    test_r_sub();
    test_alu_ops();
    test_branch();
    test_reset_mid_load();
    test_load();
    test_store();
    test_jal();
    test_store_timeout();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1);
  end

endmodule
